// File: rtl/paddle_pot_emu.sv
// Emulates a paddle pot RC charge: pot_o rises (pos << SCALE) ce ticks after discharge release.
// Latency: pos updates on the clk of a vs_i rising edge; pot_o is registered (1 clk after decision).
// Backpressure: none; dwn_i preempts any state and restarts the measurement.
module paddle_pot_emu #(
    parameter logic [7:0] POS_MIN   = 8'd16,
    parameter logic [7:0] POS_MAX   = 8'd240,
    parameter logic [7:0] POS_RESET = 8'd128,
    parameter logic [7:0] STEP      = 8'd2,
    parameter int         SCALE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       dwn_i,
    input  logic       vs_i,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       pot_o,
    output logic [7:0] pos_o
);

    typedef enum logic [1:0] {IDLE, DISCH, CHARGE, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  pos, pos_nx;
    logic        vs_prev;
    logic        frame_stb;
    logic [15:0] cnt, cnt_nx;
    logic [15:0] target, target_nx;
    logic [15:0] pos_scaled;
    logic        pot_nx;
    logic [8:0]  pos_dec, pos_inc;

    assign frame_stb  = vs_i & ~vs_prev;
    assign pos_scaled = 16'(pos) << SCALE;
    assign pos_o      = pos;

    // 9-bit so that underflow shows up in bit 8 and overflow cannot wrap
    assign pos_dec = {1'b0, pos} - {1'b0, STEP};
    assign pos_inc = {1'b0, pos} + {1'b0, STEP};

    always_comb begin
        pos_nx = pos;
        if (frame_stb) begin
            if (btn_up && !btn_down) begin
                if (pos_dec[8] || (pos_dec < {1'b0, POS_MIN}))
                    pos_nx = POS_MIN;
                else
                    pos_nx = pos_dec[7:0];
            end else if (btn_down && !btn_up) begin
                if (pos_inc > {1'b0, POS_MAX})
                    pos_nx = POS_MAX;
                else
                    pos_nx = pos_inc[7:0];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        target_nx = target;
        if (dwn_i) begin
            state_nx = DISCH;
            cnt_nx   = 16'd0;
        end else begin
            case (state)
                DISCH: begin
                    state_nx  = CHARGE;
                    target_nx = pos_scaled;
                    cnt_nx    = 16'd0;
                end
                CHARGE: begin
                    if (ce) begin
                        cnt_nx = cnt + 16'd1;
                        if ((cnt + 16'd1) == target)
                            state_nx = DONE;
                    end
                end
                default: ;
            endcase
        end
        pot_nx = (state_nx == IDLE) || (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pot_o   <= 1'b1;
            pos     <= POS_RESET;
            cnt     <= 16'd0;
            target  <= 16'd0;
            vs_prev <= 1'b0;
        end else begin
            state   <= state_nx;
            pot_o   <= pot_nx;
            pos     <= pos_nx;
            cnt     <= cnt_nx;
            target  <= target_nx;
            vs_prev <= vs_i;
        end
    end

endmodule

// File: doc/paddle_pot_emu.md
PADDLE_POT_EMU -- requirements
Module: paddle_pot_emu

Interface
REQ-001 Parameter POS_MIN, default 8'd16: lowest paddle position (SHALL be >= 1).
REQ-002 Parameter POS_MAX, default 8'd240: highest paddle position.
REQ-003 Parameter POS_RESET, default 8'd128: position after reset.
REQ-004 Parameter STEP, default 8'd2: position change per frame while a button is held.
REQ-005 Parameter SCALE, default 3: charge time = position << SCALE ce ticks.
REQ-006 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-007 reset  input  1  synchronous reset, active-high.
REQ-008 ce  input  1  one-clk enable at the chip clock rate; timing counter advances only when ce=1.
REQ-009 dwn_i  input  1  chip discharge pin (lpDWN/rpDWN): 1 = capacitor held discharged.
REQ-010 vs_i  input  1  vertical sync from the chip; its rising edge is the frame strobe.
REQ-011 btn_up  input  1  active-high move-up request, already merged from joystick and keyboard.
REQ-012 btn_down  input  1  active-high move-down request.
REQ-013 pot_o  output  1  emulated RC threshold to the chip pin (lpIN/rpIN): 1 = threshold reached.
REQ-014 pos_o  output  8  current paddle position, for debug and OSD.

Function
REQ-015 Position updates once per frame, on the clk where vs_i is 1 and its registered previous value is 0.
REQ-016 Position rule on a frame strobe:
  - btn_up=1, btn_down=0: pos = max(pos - STEP, POS_MIN).
  - btn_down=1, btn_up=0: pos = min(pos + STEP, POS_MAX).
  - both buttons or neither: pos holds.
REQ-017 Position arithmetic is 9-bit, so the result cannot wrap before it is clamped.
REQ-018 FSM states:
  - IDLE: pot_o=1.
  - DISCH: pot_o=0, counter cleared.
  - CHARGE: pot_o=0, counter runs.
  - DONE: pot_o=1.
REQ-019 From any state, dwn_i=1 enters DISCH on the next clk; this applies mid-CHARGE and is the highest-priority transition.
REQ-020 DISCH -> CHARGE on the first clk with dwn_i=0.
  - On that clk, target = pos << SCALE is latched into a 16-bit register and the counter is set to 0.
REQ-021 Position changes during CHARGE do not affect the latched target.
REQ-022 In CHARGE, each ce increments the 16-bit counter.
  - On the ce where counter+1 equals target, the state becomes DONE and pot_o is registered to 1 on that same edge.
  - pot_o therefore rises exactly target ce pulses after CHARGE entry.
REQ-023 DONE holds with pot_o=1 until dwn_i=1.
REQ-024 btn_up, btn_down and dwn_i are used directly; the instantiating level provides synchronisation to clk.
REQ-025 pos_o equals the internal position register at all times.

Reset
REQ-026 When reset=1 at a clk edge, the block sets:
  - state = IDLE, pot_o = 1;
  - pos = POS_RESET, pos_o = POS_RESET;
  - counter = 0, target = 0;
  - vs_i edge register = 0.
REQ-027 Reset overrides every other input, including dwn_i=1 and a simultaneous frame strobe.
REQ-028 Reset mid-CHARGE abandons the measurement; pot_o=1 on the edge following reset assertion.

Verification
REQ-029 Reset with default parameters -> pos_o=128, pot_o=1; dwn_i high 4 clks then low, ce=1 every clk -> pot_o=0 until exactly 1024 ce after CHARGE entry, then pot_o=1.
REQ-030 btn_up held for 10 frame strobes from pos 128 -> pos_o=108; held 100 more frames -> pos_o stays 16; next measurement gives pot_o high after 128 ce.
REQ-031 btn_down held for 60 frames -> pos_o=240; btn_up and btn_down both held for 5 frames -> pos_o unchanged.
REQ-032 dwn_i reasserted after 500 ce of CHARGE -> pot_o stays 0, counter restarts; after release, pot_o=1 after 1024 ce counted from the new release.
REQ-033 Frame strobe during CHARGE moves pos 128 -> 130 -> pot_o still rises at 1024 ce (latched target), and the next measurement rises at 1040 ce.
REQ-034 ce=1 only every 25th clk during CHARGE at pos 128 -> pot_o rises after 1024 ce pulses (25600 clks); reset asserted at 600 ce -> pot_o=1, pos_o=128.
